// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the unified-memory arbiter:
//   fetch port   : if_req, if_addr -> if_rdata, if_ready
//   data port    : dm_req, dm_we, dm_be, dm_addr, dm_wdata -> dm_rdata, dm_ready
//   memory port  : mem_req, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   hazard/status: stallF, stallM, err
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (core ports and memory)
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ready;

    logic            dm_req;
    logic            dm_we;
    logic [3:0]      dm_be;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_ready;

    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    logic            stallF;
    logic            stallM;
    logic            err;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ready,
        output dm_rdata, dm_ready,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output stallF, stallM, err
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ready,
        input  dm_rdata, dm_ready,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  stallF, stallM, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between the fetch port (IF) and the load/store
// port (DM). Each access is a req/ack transaction: the winner's fields are
// latched on grant, mem_req is held until mem_ack, and the read data is shown
// to the requester together with a one-cycle ready pulse. DM always wins a tie
// (it belongs to the older instruction). A watchdog aborts a grant that waits
// too long for mem_ack, returns zero data and sets a sticky err flag.
// Ports:
//   clk    - clock, all state on the rising edge
//   reset  - asynchronous, active-low
//   bus    - mem_arbiter_if.slave (IF, DM and memory buses, stalls, err)
// Parameters:
//   XLEN    - address/data width
//   TIMEOUT - max cycles spent waiting for mem_ack before abort (>= 1)
//   TW      - watchdog counter width, 2**TW > TIMEOUT
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          XLEN    = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int          TW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_D  = 3'd1,
        GNT_I  = 3'd2,
        RESP_D = 3'd3,
        RESP_I = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            lat_we;
    logic [3:0]      lat_be;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [XLEN-1:0] rdata_q;
    logic [TW-1:0]   cnt;
    logic            err_q;

    logic            in_gnt;
    logic            grant_d;
    logic            grant_i;
    logic            expired;

    assign in_gnt  = (state == GNT_D) || (state == GNT_I);
    assign expired = (cnt == TW'(TIMEOUT));

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        unique case (state)
            // RESP states arbitrate exactly like IDLE, so a waiting requester
            // is granted without an idle bubble.
            IDLE, RESP_D, RESP_I: begin
                if (bus.dm_req) begin
                    state_next = GNT_D;
                    grant_d    = 1'b1;
                end else if (bus.if_req) begin
                    state_next = GNT_I;
                    grant_i    = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            GNT_D: begin
                if (bus.mem_ack || expired) state_next = RESP_D;
            end
            GNT_I: begin
                if (bus.mem_ack || expired) state_next = RESP_I;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    // NOTE: the datapath registers are reset as well because they feed the
    // outputs, which must all read zero while reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                lat_we    <= bus.dm_we;
                lat_be    <= bus.dm_we ? bus.dm_be : 4'b0000;
                lat_addr  <= bus.dm_addr;
                lat_wdata <= bus.dm_wdata;
                cnt       <= '0;
            end else if (grant_i) begin
                lat_we    <= 1'b0;
                lat_be    <= 4'b0000;
                lat_addr  <= bus.if_addr;
                lat_wdata <= '0;
                cnt       <= '0;
            end else if (in_gnt) begin
                // A late ack still beats the watchdog in the same cycle.
                if (bus.mem_ack) begin
                    rdata_q <= lat_we ? '0 : bus.mem_rdata;
                end else if (expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Memory side is decoded from the state so mem_req falls the moment
    // reset is asserted.
    assign bus.mem_req   = in_gnt;
    assign bus.mem_we    = in_gnt & lat_we;
    assign bus.mem_be    = in_gnt ? lat_be : 4'b0000;
    assign bus.mem_addr  = in_gnt ? lat_addr : '0;
    assign bus.mem_wdata = (in_gnt && lat_we) ? lat_wdata : '0;

    assign bus.if_ready  = (state == RESP_I);
    assign bus.dm_ready  = (state == RESP_D);
    assign bus.if_rdata  = bus.if_ready ? rdata_q : '0;
    assign bus.dm_rdata  = bus.dm_ready ? rdata_q : '0;

    assign bus.stallF    = bus.if_req & ~bus.if_ready;
    assign bus.stallM    = bus.dm_req & ~bus.dm_ready;
    assign bus.err       = err_q;
endmodule
